// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller and board datapath.
package tictactoe_pkg;

    localparam int POS_W = 9;

    typedef enum logic [2:0] {
        MS_START   = 3'd0,
        MS_WAIT_X  = 3'd1,
        MS_WAIT_O  = 3'd2,
        MS_CHECK   = 3'd3,
        MS_ISSUE   = 3'd4,
        MS_RELEASE = 3'd5,
        MS_DONE    = 3'd6
    } ms_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_WRONG = 2'b01;
    localparam logic [1:0] ERR_POS   = 2'b10;
    localparam logic [1:0] ERR_BOTH  = 2'b11;

    localparam logic X_TILE = 1'b1;
    localparam logic O_TILE = 1'b0;

    // States in which a player holds the turn and the turn indicators are lit.
    function automatic logic in_turn(input ms_state_t s);
        return (s == MS_WAIT_X) || (s == MS_WAIT_O) || (s == MS_CHECK) ||
               (s == MS_ISSUE)  || (s == MS_RELEASE);
    endfunction

endpackage

// File: rtl/pos_check.sv
// Combinational legality test for a selected square: exactly one bit set and not occupied.
module pos_check
    import tictactoe_pkg::*;
(
    input  logic [POS_W-1:0] pos,
    input  logic [POS_W-1:0] occ,
    output logic             ok
);

    logic one_hot;

    // pos & (pos - 1) clears the lowest set bit; zero result with nonzero pos means one-hot.
    assign one_hot = (pos != '0) && ((pos & (pos - POS_W'(1))) == '0);
    assign ok      = one_hot && ((pos & occ) == '0);

endmodule

// File: rtl/move_scheduler.sv
// Turn controller: debounced-by-release button handling, move validation, valid/ready
// move issue to the board datapath, per-turn timeout and game-over lockout.
module move_scheduler
    import tictactoe_pkg::*;
#(
    parameter int TURN_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             buttonX,
    input  logic             buttonO,
    input  logic [POS_W-1:0] sel_pos,
    input  logic [POS_W-1:0] occ_square,
    input  logic             game_over,
    output logic             mv_valid,
    output logic [POS_W-1:0] mv_pos,
    output logic             mv_player,
    input  logic             mv_ready,
    output logic             turnX,
    output logic             turnO,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_TIMEOUT - 1);

    ms_state_t        state_q, state_d;
    logic             player_q, player_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             retry_q, retry_d;

    logic             mv_valid_d, mv_player_d, turnX_d, turnO_d, err_d, timeout_d;
    logic [POS_W-1:0] mv_pos_d;
    logic [1:0]       err_code_d;

    logic own_press, other_press, pos_ok;

    assign own_press   = (player_q == X_TILE) ? buttonX : buttonO;
    assign other_press = (player_q == X_TILE) ? buttonO : buttonX;

    pos_check u_pos_check (
        .pos (pos_q),
        .occ (occ_square),
        .ok  (pos_ok)
    );

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        state_d     = state_q;
        player_d    = player_q;
        cnt_d       = '0;
        pos_d       = pos_q;
        retry_d     = retry_q;
        mv_valid_d  = 1'b0;
        mv_pos_d    = mv_pos;
        mv_player_d = mv_player;
        err_d       = err;
        err_code_d  = err_code;
        timeout_d   = 1'b0;

        unique case (state_q)
            MS_START: state_d = MS_WAIT_X;

            MS_WAIT_X, MS_WAIT_O: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                if (own_press && !other_press) begin
                    pos_d   = sel_pos;
                    state_d = MS_CHECK;
                end else if (cnt_q == CNT_LAST) begin
                    // Forfeit: an accepted press on the last cycle still wins over the timeout.
                    timeout_d = 1'b1;
                    player_d  = ~player_q;
                    retry_d   = 1'b0;
                    state_d   = MS_RELEASE;
                end else if (own_press && other_press) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BOTH;
                end else if (other_press) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_WRONG;
                end
            end

            MS_CHECK: begin
                if (pos_ok) begin
                    mv_valid_d  = 1'b1;
                    mv_pos_d    = pos_q;
                    mv_player_d = player_q;
                    state_d     = MS_ISSUE;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_POS;
                    retry_d    = 1'b1;
                    state_d    = MS_RELEASE;
                end
            end

            MS_ISSUE: begin
                if (mv_ready) begin
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    player_d   = ~player_q;
                    retry_d    = 1'b0;
                    state_d    = MS_RELEASE;
                end else begin
                    mv_valid_d = 1'b1;
                end
            end

            MS_RELEASE: begin
                // Buttons must go low before another press can be seen.
                if (!buttonX && !buttonO) begin
                    retry_d = 1'b0;
                    if (game_over && !retry_q)
                        state_d = MS_DONE;
                    else
                        state_d = (player_q == X_TILE) ? MS_WAIT_X : MS_WAIT_O;
                end
            end

            MS_DONE: state_d = MS_DONE;

            default: state_d = MS_START;
        endcase

        turnX_d = in_turn(state_d) && (player_d == X_TILE);
        turnO_d = in_turn(state_d) && (player_d == O_TILE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MS_START;
            player_q  <= X_TILE;
            cnt_q     <= '0;
            pos_q     <= '0;
            retry_q   <= 1'b0;
            mv_valid  <= 1'b0;
            mv_pos    <= '0;
            mv_player <= X_TILE;
            turnX     <= 1'b0;
            turnO     <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            retry_q   <= retry_d;
            mv_valid  <= mv_valid_d;
            mv_pos    <= mv_pos_d;
            mv_player <= mv_player_d;
            turnX     <= turnX_d;
            turnO     <= turnO_d;
            err       <= err_d;
            err_code  <= err_code_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed scenarios plus randomized turns
// checked against a turn-level reference model.
module tb_move_scheduler;
    import tictactoe_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset, buttonX, buttonO, game_over, mv_ready;
    logic [8:0] sel_pos, occ_square, mv_pos;
    logic       mv_valid, mv_player, turnX, turnO, err, timeout;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    move_scheduler #(.TURN_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .buttonX    (buttonX),
        .buttonO    (buttonO),
        .sel_pos    (sel_pos),
        .occ_square (occ_square),
        .game_over  (game_over),
        .mv_valid   (mv_valid),
        .mv_pos     (mv_pos),
        .mv_player  (mv_player),
        .mv_ready   (mv_ready),
        .turnX      (turnX),
        .turnO      (turnO),
        .err        (err),
        .err_code   (err_code),
        .timeout    (timeout)
    );

    // Observed status vector: {mv_valid, timeout, err, err_code, turnX, turnO}
    function automatic logic [6:0] status();
        return {mv_valid, timeout, err, err_code, turnX, turnO};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        buttonX = 0; buttonO = 0; mv_ready = 0; game_over = 0;
    endtask

    // Leaves the DUT in its first WAIT_X cycle.
    task automatic reset_to_wait();
        quiet_inputs();
        reset = 1; step();
        reset = 0; step();
    endtask

    task automatic test_reset();
        quiet_inputs();
        sel_pos = 9'h1FF; occ_square = 9'h000;
        reset = 1; step(); step();
        checks++;
        if (status() !== 7'b0_0_0_00_0_0) begin
            errors++; $display("FAIL reset_status got %b want %b", status(), 7'b0);
        end
        checks++;
        if (mv_pos !== 9'h000 || mv_player !== 1'b1) begin
            errors++; $display("FAIL reset_move got pos %h player %b want pos 000 player 1", mv_pos, mv_player);
        end
        reset = 0; step();
        checks++;
        if (status() !== 7'b0_0_0_00_1_0) begin
            errors++; $display("FAIL reset_to_wait_x got %b want %b", status(), 7'b0000010);
        end
    endtask

    task automatic test_basic_move();
        reset_to_wait();
        sel_pos = 9'h010; occ_square = 9'h000; buttonX = 1;
        step();
        checks++;
        if (mv_valid !== 1'b0) begin
            errors++; $display("FAIL basic_check_cycle mv_valid got %b want 0", mv_valid);
        end
        step();
        checks++;
        if (mv_valid !== 1'b1 || mv_pos !== 9'h010 || mv_player !== 1'b1) begin
            errors++; $display("FAIL basic_offer got v%b pos %h p%b want v1 pos 010 p1", mv_valid, mv_pos, mv_player);
        end
        mv_ready = 1; step(); mv_ready = 0;
        checks++;
        if (status() !== 7'b0_0_0_00_0_1) begin
            errors++; $display("FAIL basic_handshake got %b want %b", status(), 7'b0000001);
        end
        buttonX = 0; step();
        checks++;
        if (status() !== 7'b0_0_0_00_0_1) begin
            errors++; $display("FAIL basic_wait_o got %b want %b", status(), 7'b0000001);
        end
    endtask

    task automatic test_wrong_button();
        reset_to_wait();
        buttonO = 1; step();
        checks++;
        if (status() !== 7'b0_0_1_01_1_0) begin
            errors++; $display("FAIL wrong_button got %b want %b", status(), 7'b0010110);
        end
        buttonO = 0; buttonX = 1; sel_pos = 9'h001; occ_square = 9'h000;
        step(); step();
        checks++;
        if (mv_valid !== 1'b1 || mv_pos !== 9'h001 || err !== 1'b1) begin
            errors++; $display("FAIL wrong_then_offer got v%b pos %h err %b want v1 pos 001 err 1", mv_valid, mv_pos, err);
        end
        mv_ready = 1; step(); mv_ready = 0; buttonX = 0;
        checks++;
        if (err !== 1'b0 || err_code !== ERR_NONE || mv_valid !== 1'b0) begin
            errors++; $display("FAIL err_clear got err %b code %b v%b want 0 00 0", err, err_code, mv_valid);
        end
        step();
    endtask

    task automatic test_bad_position();
        logic [8:0] bad_pos [2];
        logic [8:0] bad_occ [2];
        bad_pos[0] = 9'h011; bad_occ[0] = 9'h000;
        bad_pos[1] = 9'h004; bad_occ[1] = 9'h004;
        reset_to_wait();
        for (int k = 0; k < 2; k++) begin
            sel_pos = bad_pos[k]; occ_square = bad_occ[k]; buttonX = 1;
            step(); buttonX = 0; step();
            checks++;
            if (status() !== 7'b0_0_1_10_1_0) begin
                errors++; $display("FAIL bad_pos_%0d got %b want %b", k, status(), 7'b0011010);
            end
            step();
            checks++;
            if (status() !== 7'b0_0_1_10_1_0) begin
                errors++; $display("FAIL bad_pos_back_%0d got %b want %b", k, status(), 7'b0011010);
            end
        end
        sel_pos = 9'h002; buttonX = 1;
        step(); buttonX = 0; step();
        checks++;
        if (mv_valid !== 1'b1 || mv_pos !== 9'h002 || mv_player !== 1'b1) begin
            errors++; $display("FAIL bad_pos_retry got v%b pos %h p%b want v1 pos 002 p1", mv_valid, mv_pos, mv_player);
        end
        mv_ready = 1; step(); mv_ready = 0; step();
    endtask

    task automatic test_back_pressure();
        logic [8:0] p;
        p = 9'(1) << $urandom_range(0, 8);
        reset_to_wait();
        sel_pos = p; occ_square = ~p; buttonX = 1;
        step(); buttonX = 0; sel_pos = 9'h1FF; step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mv_valid !== 1'b1 || mv_pos !== p || mv_player !== 1'b1) begin
                errors++; $display("FAIL stall_%0d got v%b pos %h p%b want v1 pos %h p1", i, mv_valid, mv_pos, mv_player, p);
            end
            if (i < 5) begin
                sel_pos = 9'($urandom_range(0, 511));
                step();
            end
        end
        mv_ready = 1; step(); mv_ready = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mv_valid !== 1'b0) begin
                errors++; $display("FAIL single_handshake_%0d mv_valid got %b want 0", i, mv_valid);
            end
            step();
        end
    endtask

    task automatic test_timeout();
        reset_to_wait();
        for (int i = 0; i < TO - 1; i++) begin
            step();
            checks++;
            if (status() !== 7'b0_0_0_00_1_0) begin
                errors++; $display("FAIL timeout_early_%0d got %b want %b", i, status(), 7'b0000010);
            end
        end
        step();
        checks++;
        if (status() !== 7'b0_1_0_00_0_1) begin
            errors++; $display("FAIL timeout_pulse got %b want %b", status(), 7'b0100001);
        end
        step();
        checks++;
        if (status() !== 7'b0_0_0_00_0_1) begin
            errors++; $display("FAIL timeout_after got %b want %b", status(), 7'b0000001);
        end
    endtask

    task automatic test_game_over();
        reset_to_wait();
        sel_pos = 9'h100; occ_square = 9'h000; buttonX = 1;
        step(); buttonX = 0; step();
        mv_ready = 1; step(); mv_ready = 0; game_over = 1;
        step();
        checks++;
        if (status() !== 7'b0) begin
            errors++; $display("FAIL done_entry got %b want %b", status(), 7'b0);
        end
        for (int i = 0; i < 10; i++) begin
            buttonX = i[0]; buttonO = i[1]; sel_pos = 9'(1) << (i % 9);
            step();
            checks++;
            if (status() !== 7'b0) begin
                errors++; $display("FAIL done_ignore_%0d got %b want %b", i, status(), 7'b0);
            end
        end
        quiet_inputs();
    endtask

    task automatic test_reset_mid_issue();
        reset_to_wait();
        sel_pos = 9'h080; occ_square = 9'h000; buttonX = 1;
        step(); buttonX = 0; step();
        checks++;
        if (mv_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_offer mv_valid got %b want 1", mv_valid);
        end
        reset = 1; step(); reset = 0;
        checks++;
        if (status() !== 7'b0 || mv_pos !== 9'h000) begin
            errors++; $display("FAIL reset_in_issue got %b pos %h want %b pos 000", status(), mv_pos, 7'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mv_valid !== 1'b0) begin
                errors++; $display("FAIL no_retained_move_%0d mv_valid got %b want 0", i, mv_valid);
            end
        end
    endtask

    // Turn-level model: tracks the player to move and the sticky error only.
    task automatic test_random();
        bit         p;
        bit         e;
        logic [1:0] ec;
        logic [6:0] exp_st;
        reset_to_wait();
        p = 1; e = 0; ec = ERR_NONE;
        for (int t = 0; t < 60; t++) begin
            bit         forfeit;
            int         n_idle, rdy, hold;
            logic [8:0] pos, occ;
            bit         ok;
            forfeit = ($urandom_range(0, 3) == 0);
            n_idle  = forfeit ? TO : $urandom_range(0, TO - 1);
            for (int i = 0; i < n_idle; i++) begin
                int pat;
                bit to_now;
                pat = $urandom_range(0, 3);
                buttonX = 0; buttonO = 0;
                if (pat == 3) begin buttonX = 1; buttonO = 1; end
                else if (pat == 2) begin if (p) buttonO = 1; else buttonX = 1; end
                step();
                to_now = (i == TO - 1);
                if (to_now) p = ~p;
                else if (pat == 3) begin e = 1; ec = ERR_BOTH; end
                else if (pat == 2) begin e = 1; ec = ERR_WRONG; end
                exp_st = {1'b0, to_now, e, ec, p, ~p};
                checks++;
                if (status() !== exp_st) begin
                    errors++; $display("FAIL rnd_idle t%0d i%0d got %b want %b", t, i, status(), exp_st);
                end
            end
            if (!forfeit) begin
                pos = $urandom_range(0, 1) ? (9'(1) << $urandom_range(0, 8)) : 9'($urandom_range(0, 511));
                occ = 9'($urandom_range(0, 511)) & 9'($urandom_range(0, 511));
                ok  = ($countones(pos) == 1) && ((pos & occ) == 9'h000);
                hold = $urandom_range(0, 2);
                buttonX = p; buttonO = ~p; sel_pos = pos; occ_square = occ;
                step();
                sel_pos = 9'($urandom_range(0, 511));
                if (hold == 0) begin buttonX = 0; buttonO = 0; end
                step();
                if (ok) begin
                    rdy = $urandom_range(0, 3);
                    for (int r = 0; r <= rdy; r++) begin
                        exp_st = {1'b1, 1'b0, e, ec, p, ~p};
                        checks++;
                        if (status() !== exp_st || mv_pos !== pos || mv_player !== p) begin
                            errors++; $display("FAIL rnd_offer t%0d r%0d got %b pos %h p%b want %b pos %h p%b",
                                               t, r, status(), mv_pos, mv_player, exp_st, pos, p);
                        end
                        mv_ready = (r == rdy);
                        step();
                    end
                    mv_ready = 0;
                    e = 0; ec = ERR_NONE; p = ~p;
                end else begin
                    e = 1; ec = ERR_POS;
                end
                exp_st = {1'b0, 1'b0, e, ec, p, ~p};
                for (int h = 0; h <= hold; h++) begin
                    checks++;
                    if (status() !== exp_st) begin
                        errors++; $display("FAIL rnd_release t%0d h%0d got %b want %b", t, h, status(), exp_st);
                    end
                    if (h == hold) begin buttonX = 0; buttonO = 0; end
                    step();
                end
            end else begin
                buttonX = 0; buttonO = 0;
                step();
            end
            exp_st = {1'b0, 1'b0, e, ec, p, ~p};
            checks++;
            if (status() !== exp_st) begin
                errors++; $display("FAIL rnd_wait t%0d got %b want %b", t, status(), exp_st);
            end
        end
    endtask

    initial begin
        reset = 1;
        quiet_inputs();
        sel_pos = '0; occ_square = '0;
        test_reset();
        test_basic_move();
        test_wrong_button();
        test_bad_position();
        test_back_pressure();
        test_timeout();
        test_game_over();
        test_reset_mid_issue();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
